// File: rtl/ctrl_pkg.sv
// Shared control-path definitions for the pipelined MIPS control unit:
// opcodes, bundle widths and named bit positions inside each bundle.
package ctrl_pkg;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] NOP   = 6'b100000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;

  localparam int unsigned EX_W = 4;
  localparam int unsigned M_W  = 3;
  localparam int unsigned WB_W = 2;

  // EX bundle: {RegDst, ALUOp[1:0], ALUSrc}
  localparam int unsigned EX_REGDST   = 3;
  localparam int unsigned EX_ALUOP_HI = 2;
  localparam int unsigned EX_ALUOP_LO = 1;
  localparam int unsigned EX_ALUSRC   = 0;

  // M bundle: {Branch, MemRead, MemWrite}
  localparam int unsigned M_BRANCH   = 2;
  localparam int unsigned M_MEMREAD  = 1;
  localparam int unsigned M_MEMWRITE = 0;

  // WB bundle: {RegWrite, MemToReg}
  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder producing EX/M/WB control bundles,
// the jump indication and an unknown-opcode flag.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]      opcode_i,
  output logic [EX_W-1:0] ex_o,
  output logic [M_W-1:0]  m_o,
  output logic [WB_W-1:0] wb_o,
  output logic            jump_o,
  output logic            illegal_o
);

  always_comb begin
    ex_o      = '0;
    m_o       = '0;
    wb_o      = '0;
    jump_o    = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      RTYPE: begin
        ex_o[EX_REGDST]   = 1'b1;
        ex_o[EX_ALUOP_HI] = 1'b1;
        wb_o[WB_REGWRITE] = 1'b1;
      end
      LW: begin
        ex_o[EX_ALUSRC]   = 1'b1;
        m_o[M_MEMREAD]    = 1'b1;
        wb_o[WB_REGWRITE] = 1'b1;
        wb_o[WB_MEMTOREG] = 1'b1;
      end
      SW: begin
        ex_o[EX_ALUSRC]  = 1'b1;
        m_o[M_MEMWRITE]  = 1'b1;
      end
      BEQ: begin
        ex_o[EX_ALUOP_LO] = 1'b1;
        m_o[M_BRANCH]     = 1'b1;
      end
      ADDI: begin
        ex_o[EX_ALUSRC]   = 1'b1;
        wb_o[WB_REGWRITE] = 1'b1;
      end
      J:       jump_o    = 1'b1;
      NOP:     ;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_control.sv
// ID-stage control unit: decodes the ID opcode and carries control bundles
// through ID/EX, EX/MEM and MEM/WB, with load-use stall and branch flush.
module pipe_control
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          HAZARD_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  flush_i,
  output logic [EX_W-1:0]       idex_ex,
  output logic [M_W-1:0]        idex_m,
  output logic [WB_W-1:0]       idex_wb,
  output logic [REG_ADDR_W-1:0] idex_rt,
  output logic [M_W-1:0]        exmem_m,
  output logic [WB_W-1:0]       exmem_wb,
  output logic [WB_W-1:0]       memwb_wb,
  output logic                  jump_o,
  output logic                  stall_o,
  output logic                  illegal_o
);

  logic [EX_W-1:0]       dec_ex;
  logic [M_W-1:0]        dec_m;
  logic [WB_W-1:0]       dec_wb;
  logic                  dec_illegal;

  logic [EX_W-1:0]       idex_ex_q, idex_ex_d;
  logic [M_W-1:0]        idex_m_q, idex_m_d;
  logic [WB_W-1:0]       idex_wb_q, idex_wb_d;
  logic [REG_ADDR_W-1:0] idex_rt_q, idex_rt_d;
  logic [M_W-1:0]        exmem_m_q, exmem_m_d;
  logic [WB_W-1:0]       exmem_wb_q, exmem_wb_d;
  logic [WB_W-1:0]       memwb_wb_q, memwb_wb_d;
  logic                  illegal_q, illegal_d;
  logic                  load_use;

  ctrl_decode u_decode (
    .opcode_i  (id_opcode),
    .ex_o      (dec_ex),
    .m_o       (dec_m),
    .wb_o      (dec_wb),
    .jump_o    (jump_o),
    .illegal_o (dec_illegal)
  );

  // A load in EX whose destination is a source of the ID instruction; r0 never hazards.
  assign load_use = idex_m_q[M_MEMREAD] && (idex_rt_q != '0) &&
                    ((idex_rt_q == id_rs) || (idex_rt_q == id_rt));
  assign stall_o  = HAZARD_EN && load_use && !flush_i;

  always_comb begin
    memwb_wb_d = exmem_wb_q;
    if (flush_i) begin
      idex_ex_d  = '0;
      idex_m_d   = '0;
      idex_wb_d  = '0;
      idex_rt_d  = '0;
      exmem_m_d  = '0;
      exmem_wb_d = '0;
      illegal_d  = 1'b0;
    end else if (stall_o) begin
      idex_ex_d  = '0;
      idex_m_d   = '0;
      idex_wb_d  = '0;
      idex_rt_d  = '0;
      exmem_m_d  = idex_m_q;
      exmem_wb_d = idex_wb_q;
      illegal_d  = 1'b0;
    end else begin
      idex_ex_d  = dec_ex;
      idex_m_d   = dec_m;
      idex_wb_d  = dec_wb;
      idex_rt_d  = id_rt;
      exmem_m_d  = idex_m_q;
      exmem_wb_d = idex_wb_q;
      illegal_d  = dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_ex_q  <= '0;
      idex_m_q   <= '0;
      idex_wb_q  <= '0;
      idex_rt_q  <= '0;
      exmem_m_q  <= '0;
      exmem_wb_q <= '0;
      memwb_wb_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      idex_ex_q  <= idex_ex_d;
      idex_m_q   <= idex_m_d;
      idex_wb_q  <= idex_wb_d;
      idex_rt_q  <= idex_rt_d;
      exmem_m_q  <= exmem_m_d;
      exmem_wb_q <= exmem_wb_d;
      memwb_wb_q <= memwb_wb_d;
      illegal_q  <= illegal_d;
    end
  end

  assign idex_ex   = idex_ex_q;
  assign idex_m    = idex_m_q;
  assign idex_wb   = idex_wb_q;
  assign idex_rt   = idex_rt_q;
  assign exmem_m   = exmem_m_q;
  assign exmem_wb  = exmem_wb_q;
  assign memwb_wb  = memwb_wb_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: two instances (hazard detection on/off)
// share random and directed stimulus; a reference model predicts each cycle.
module tb_pipe_control;

  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_i = 1'b0;
  logic [5:0]    id_opcode = 6'b100011;
  logic [RW-1:0] id_rs = '0;
  logic [RW-1:0] id_rt = '0;

  logic [3:0]    a_idex_ex, b_idex_ex;
  logic [2:0]    a_idex_m, b_idex_m, a_exmem_m, b_exmem_m;
  logic [1:0]    a_idex_wb, b_idex_wb, a_exmem_wb, b_exmem_wb, a_memwb_wb, b_memwb_wb;
  logic [RW-1:0] a_idex_rt, b_idex_rt;
  logic          a_jump, b_jump, a_stall, b_stall, a_ill, b_ill;

  always #5 clk = ~clk;

  // index 1: hazard detection enabled, index 0: disabled
  pipe_control #(.REG_ADDR_W(RW), .HAZARD_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .flush_i(flush_i), .idex_ex(a_idex_ex), .idex_m(a_idex_m), .idex_wb(a_idex_wb),
    .idex_rt(a_idex_rt), .exmem_m(a_exmem_m), .exmem_wb(a_exmem_wb),
    .memwb_wb(a_memwb_wb), .jump_o(a_jump), .stall_o(a_stall), .illegal_o(a_ill)
  );

  pipe_control #(.REG_ADDR_W(RW), .HAZARD_EN(1'b0)) u_dut_nh (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .flush_i(flush_i), .idex_ex(b_idex_ex), .idex_m(b_idex_m), .idex_wb(b_idex_wb),
    .idex_rt(b_idex_rt), .exmem_m(b_exmem_m), .exmem_wb(b_exmem_wb),
    .memwb_wb(b_memwb_wb), .jump_o(b_jump), .stall_o(b_stall), .illegal_o(b_ill)
  );

  logic [21:0] obs1, obs0;
  assign obs1 = {a_idex_ex, a_idex_m, a_idex_wb, a_idex_rt, a_exmem_m, a_exmem_wb,
                 a_memwb_wb, a_ill};
  assign obs0 = {b_idex_ex, b_idex_m, b_idex_wb, b_idex_rt, b_exmem_m, b_exmem_wb,
                 b_memwb_wb, b_ill};

  int checks = 0;
  int errors = 0;

  logic [43:0] rq[$];  // {haz-on regs, haz-off regs} expected after next edge
  logic [3:0]  cq[$];  // {jump1, stall1, jump0, stall0} expected this cycle

  // Reference model state, one copy per hazard setting
  logic [3:0]    m_ex[2];
  logic [2:0]    m_m[2];
  logic [1:0]    m_wb[2];
  logic [RW-1:0] m_rt[2];
  logic [2:0]    m_xm[2];
  logic [1:0]    m_xwb[2];
  logic [1:0]    m_mwb[2];
  logic          m_ill[2];

  // {known, ex, m, wb} straight from the opcode table
  function automatic logic [9:0] ref_dec(input logic [5:0] op);
    case (op)
      6'b000000: return {1'b1, 4'b1100, 3'b000, 2'b10};
      6'b100011: return {1'b1, 4'b0001, 3'b010, 2'b11};
      6'b101011: return {1'b1, 4'b0001, 3'b001, 2'b00};
      6'b000100: return {1'b1, 4'b0010, 3'b100, 2'b00};
      6'b001000: return {1'b1, 4'b0001, 3'b000, 2'b10};
      6'b000010: return {1'b1, 9'b0};
      6'b100000: return {1'b1, 9'b0};
      default:   return 10'b0;
    endcase
  endfunction

  function automatic logic [5:0] pick_op(input int unsigned k);
    case (k)
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b001000;
      5: return 6'b000010;
      6: return 6'b100000;
      default: return 6'($urandom);
    endcase
  endfunction

  task automatic step(input logic [5:0] op, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                      input logic fl, input logic r);
    logic [3:0]  cexp;
    logic [43:0] rexp;
    logic [9:0]  d;
    logic        stall;
    @(negedge clk);
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    flush_i   = fl;
    rst       = r;
    d = ref_dec(op);
    for (int h = 0; h < 2; h++) begin
      stall = (h == 1) && m_m[h][1] && (m_rt[h] != 0) && (m_rt[h] == rs || m_rt[h] == rt)
              && !fl;
      cexp[2*h +: 2] = {op == 6'b000010, stall};
      if (r) begin
        m_ex[h] = 0; m_m[h] = 0; m_wb[h] = 0; m_rt[h] = 0;
        m_xm[h] = 0; m_xwb[h] = 0; m_mwb[h] = 0; m_ill[h] = 0;
      end else begin
        m_mwb[h] = m_xwb[h];
        if (fl) begin
          m_xm[h] = 0; m_xwb[h] = 0;
        end else begin
          m_xm[h] = m_m[h]; m_xwb[h] = m_wb[h];
        end
        if (fl || stall) begin
          m_ex[h] = 0; m_m[h] = 0; m_wb[h] = 0; m_rt[h] = 0; m_ill[h] = 0;
        end else begin
          m_ex[h] = d[8:5]; m_m[h] = d[4:2]; m_wb[h] = d[1:0]; m_rt[h] = rt;
          m_ill[h] = !d[9];
        end
      end
      rexp[22*h +: 22] = {m_ex[h], m_m[h], m_wb[h], m_rt[h], m_xm[h], m_xwb[h], m_mwb[h],
                          m_ill[h]};
    end
    cq.push_back(cexp);
    rq.push_back(rexp);
  endtask

  // Monitor: registered outputs just after the edge
  always @(posedge clk) begin
    logic [43:0] e;
    #1;
    if (rq.size() > 0) begin
      e = rq.pop_front();
      checks++;
      if (obs1 !== e[43:22]) begin
        errors++;
        $display("FAIL regs_haz1 t=%0t got=%h exp=%h", $time, obs1, e[43:22]);
      end
      checks++;
      if (obs0 !== e[21:0]) begin
        errors++;
        $display("FAIL regs_haz0 t=%0t got=%h exp=%h", $time, obs0, e[21:0]);
      end
    end
  end

  // Monitor: combinational outputs mid-cycle
  always @(negedge clk) begin
    logic [3:0] e;
    #2;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      checks++;
      if ({a_jump, a_stall, b_jump, b_stall} !== e) begin
        errors++;
        $display("FAIL comb_jump_stall t=%0t got=%b exp=%b", $time,
                 {a_jump, a_stall, b_jump, b_stall}, e);
      end
    end
  end

  initial begin
    logic [5:0] ops[7];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b100000};
    // reset with LW presented, then LW flows through all stages
    step(6'b100011, 0, 1, 0, 1);
    step(6'b100011, 0, 1, 0, 1);
    step(6'b100011, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(6'b100000, 0, 0, 0, 0);
    // opcode sweep, each followed by an illegal opcode
    foreach (ops[i]) begin
      step(ops[i], 1, 2, 0, 0);
      step(6'b111111, 1, 2, 0, 0);
    end
    // load-use with rt=5, then with rt=0
    step(6'b100011, 0, 5, 0, 0);
    step(6'b000000, 5, 0, 0, 0);
    step(6'b000000, 5, 0, 0, 0);
    step(6'b100000, 0, 0, 0, 0);
    step(6'b100011, 0, 0, 0, 0);
    step(6'b000000, 0, 0, 0, 0);
    step(6'b100000, 0, 0, 0, 0);
    // flush with a pipeline full, and flush during a load-use hazard
    step(6'b100011, 0, 3, 0, 0);
    step(6'b101011, 0, 4, 0, 0);
    step(6'b000000, 1, 2, 0, 0);
    step(6'b111111, 3, 3, 1, 0);
    step(6'b100000, 0, 0, 0, 0);
    step(6'b100011, 0, 5, 0, 0);
    step(6'b000000, 5, 5, 1, 0);
    step(6'b100000, 0, 0, 0, 0);
    // reset with every stage busy and an illegal opcode in ID
    step(6'b100011, 0, 6, 0, 0);
    step(6'b000000, 1, 2, 0, 0);
    step(6'b001000, 1, 2, 0, 0);
    step(6'b111111, 0, 0, 0, 1);
    step(6'b100000, 0, 0, 0, 0);
    // random traffic; small register range makes hazards frequent
    for (int i = 0; i < 1500; i++) begin
      step(pick_op($urandom_range(0, 8)), RW'($urandom_range(0, 3)),
           RW'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 39) == 0));
    end
    @(posedge clk);
    #3;
    checks++;
    if (rq.size() != 0 || cq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got rq=%0d cq=%0d exp 0 0", rq.size(), cq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_control.md
# pipe_control

- Pipelined successor to the combinational opcode decoder; sits in the ID stage of the 5-stage MIPS datapath.
- Decodes the ID-stage opcode into EX/M/WB control bundles and carries them through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards, inserting a bubble and asserting a stall.
- Handles branch flush; adds ADDI and J support and flags illegal opcodes.

## Interface
Parameters:
- REG_ADDR_W, 5, register-specifier width
- HAZARD_EN, 1, 1 enables load-use detection; 0 forces stall_o=0

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_opcode  in  6  opcode of instruction in ID
- id_rs  in  REG_ADDR_W  rs of instruction in ID
- id_rt  in  REG_ADDR_W  rt of instruction in ID
- flush_i  in  1  branch taken; squash younger control
- idex_ex  out  4  {RegDst, ALUOp[1:0], ALUSrc}
- idex_m  out  3  {Branch, MemRead, MemWrite}
- idex_wb  out  2  {RegWrite, MemToReg}
- idex_rt  out  REG_ADDR_W  registered rt (forwarding/hazard)
- exmem_m  out  3  M bundle in EX/MEM
- exmem_wb  out  2  WB bundle in EX/MEM
- memwb_wb  out  2  WB bundle in MEM/WB
- jump_o  out  1  combinational; ID opcode is J
- stall_o  out  1  combinational; freeze PC and IF/ID
- illegal_o  out  1  registered one-cycle pulse, unknown opcode

## Operation
Decode, combinational, EX/M/WB:
- RTYPE 000000 → 1100/000/10
- LW 100011 → 0001/010/11
- SW 101011 → 0001/001/00
- BEQ 000100 → 0010/100/00
- ADDI 001000 → 0001/000/10
- J 000010 → all zero, jump_o=1
- NOP 100000 → all zero
- Any other opcode → all zero; illegal_o pulses next cycle.
- Don't-care bits are driven 0, never X/Z.

Load-use hazard:
- stall_o = HAZARD_EN & idex_m[1] & (idex_rt != 0) & (idex_rt == id_rs | idex_rt == id_rt) & ~flush_i.

Per rising clk edge, priority order:
- rst: every registered output is 0 (idex_ex, idex_m, idex_wb, idex_rt, exmem_*, memwb_wb, illegal_o).
- flush_i: ID/EX and EX/MEM bundles load 0; memwb_wb <= exmem_wb; idex_rt <= 0; illegal_o <= 0.
- stall_o: ID/EX bundles load 0 (bubble); idex_rt <= 0; exmem_* <= idex_*; memwb_wb <= exmem_wb; illegal_o <= 0.
- Otherwise:
  - idex_* <= decode; idex_rt <= id_rt
  - exmem_m/wb <= idex_m/wb
  - memwb_wb <= exmem_wb
  - illegal_o <= unknown opcode

## Timing
- Decode to idex_* latency: 1 cycle; to exmem_*: 2 cycles; to memwb_wb: 3 cycles.
- stall_o, jump_o: same cycle as inputs, no register.
- Load-use stall lasts exactly one cycle:
  - The bubble clears idex_m[1], so stall_o deasserts the next cycle with the same ID instruction re-presented.
- flush_i and stall condition together: flush wins; stall_o=0.
- rst asserted mid-stream: all in-flight control is discarded at that edge. The first decode is captured on the first edge after rst deasserts.
- An illegal opcode during stall or flush sets no illegal_o pulse. The instruction is re-decoded when it advances.

## Structure
- Shared package ctrl_pkg holds:
  - opcode constants RTYPE, LW, SW, BEQ, ADDI, J, NOP
  - bundle widths EX_W=4, M_W=3, WB_W=2
  - named bit indices, e.g. M_MEMREAD=1
- Sub-module ctrl_decode: the pure combinational opcode → {ex, m, wb, jump, illegal} decoder.
- pipe_control holds the pipeline registers and the hazard/flush logic.

## Test plan
- Reset: hold rst 2 cycles with opcode=LW → all outputs 0. After release, LW yields idex_ex=0001, idex_m=010, idex_wb=11 one edge later; exmem_wb=11 after 2 edges; memwb_wb=11 after 3 edges.
- Opcode sweep: each opcode (RTYPE, LW, SW, BEQ, ADDI, J, NOP) followed by 111111 → idex bundles match the table; jump_o=1 only for J; illegal_o pulses once, only for 111111.
- Load-use: LW rt=5 followed by RTYPE rs=5 → stall_o=1 for one cycle, then idex_m=000 bubble, then RTYPE decoded; same sequence with rt=0 → no stall.
- HAZARD_EN=0: repeat the load-use case → stall_o never asserts.
- Flush: LW, SW, RTYPE in flight, then flush_i for one cycle → idex_* and exmem_* become 0; memwb_wb keeps the advancing value; flush during a load-use hazard → stall_o=0.
- Reset mid-stream: assert rst with all stages holding nonzero bundles → all outputs 0 at that edge; no illegal_o.
